// File: rtl/ram_bist.sv
// BIST initiator for the single-port ram1: fill, read back, compare, report.
// Optional RAM_BIST_INV_PASS_EN adds a second pass with the inverted pattern.
module ram_bist #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SEED       = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [ADDR_WIDTH:0]   err_cnt,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam logic [ADDR_WIDTH-1:0] AddrOne = 1;
  localparam logic [ADDR_WIDTH:0]   ErrOne  = 1;

  typedef enum logic [2:0] {StIdle, StWrite, StRead, StCheck, StDone} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [ADDR_WIDTH-1:0] fail_q, fail_d;
  logic [ADDR_WIDTH:0]   err_q, err_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  seen_q, seen_d;
  // Two-stage read tracker: stage 1 = address presented, stage 2 = RAM data now valid.
  logic                  v1_q, v1_d, v2_q;
  logic [ADDR_WIDTH-1:0] a1_q, a1_d, a2_q;
  logic                  wr_inv, cmp_inv;
  logic                  mismatch;

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a,
                                                     input logic inv);
    logic [DATA_WIDTH-1:0] p;
    p = DATA_WIDTH'(a) + DATA_WIDTH'(SEED);
    return inv ? ~p : p;
  endfunction

`ifdef RAM_BIST_INV_PASS_EN
  logic phase_q, phase_d;
  logic inv1_q, inv2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= 1'b0;
      inv1_q  <= 1'b0;
      inv2_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      inv1_q  <= phase_q;
      inv2_q  <= inv1_q;
    end
  end

  assign wr_inv  = phase_q;
  assign cmp_inv = inv2_q;
`else
  assign wr_inv  = 1'b0;
  assign cmp_inv = 1'b0;
`endif

  assign mismatch = v2_q && (ram_rdata != pattern(a2_q, cmp_inv));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;
    fail_d  = fail_q;
    err_d   = err_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    seen_d  = seen_q;
    v1_d    = 1'b0;
    a1_d    = a1_q;
`ifdef RAM_BIST_INV_PASS_EN
    phase_d = phase_q;
`endif

    // Compares run off the pipeline, independent of state, so the last one may land in DONE.
    if (mismatch) begin
      if (err_q != '1) err_d = err_q + ErrOne;
      if (!seen_q) begin
        seen_d = 1'b1;
        fail_d = a2_q;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StWrite;
          cnt_d   = '0;
          err_d   = '0;
          fail_d  = '0;
          pass_d  = 1'b0;
          seen_d  = 1'b0;
`ifdef RAM_BIST_INV_PASS_EN
          phase_d = 1'b0;
`endif
        end
      end
      StWrite: begin
        busy_d  = 1'b1;
        we_d    = 1'b1;
        addr_d  = cnt_q;
        wdata_d = pattern(cnt_q, wr_inv);
        cnt_d   = cnt_q + AddrOne;
        if (&cnt_q) state_d = StRead;
      end
      StRead: begin
        busy_d = 1'b1;
        addr_d = cnt_q;
        v1_d   = 1'b1;
        a1_d   = cnt_q;
        cnt_d  = cnt_q + AddrOne;
        if (&cnt_q) state_d = StCheck;
      end
      StCheck: begin
        busy_d  = 1'b1;
        state_d = StDone;
`ifdef RAM_BIST_INV_PASS_EN
        if (!phase_q) begin
          phase_d = 1'b1;
          state_d = StWrite;
        end
`endif
      end
      StDone: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = (err_d == '0);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= '0;
      err_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      seen_q  <= 1'b0;
      v1_q    <= 1'b0;
      a1_q    <= '0;
      v2_q    <= 1'b0;
      a2_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      seen_q  <= seen_d;
      v1_q    <= v1_d;
      a1_q    <= a1_d;
      v2_q    <= v1_q;
      a2_q    <= a1_q;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_addr = fail_q;
  assign err_cnt   = err_q;
  assign ram_addr  = addr_q;
  assign ram_we    = we_q;
  assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_ram_bist.sv
// Directed bench for ram_bist: behavioural RAM with fault injection, plus a 4-bit wrap instance.
module tb_ram_bist;

`ifdef RAM_BIST_INV_PASS_EN
  localparam int ExpDone   = 67;
  localparam int ExpWrites = 32;
  localparam int ExpSa1Err = 1;
  localparam int ExpFfErr  = 31;
`else
  localparam int ExpDone   = 34;
  localparam int ExpWrites = 16;
  localparam int ExpSa1Err = 0;
  localparam int ExpFfErr  = 16;
`endif

  logic       clk = 1'b0;
  logic       rst, start, start2;
  logic       busy, done, pass, ram_we;
  logic [3:0] fail_addr, ram_addr;
  logic [4:0] err_cnt;
  logic [7:0] ram_wdata, ram_rdata;
  logic       busy2, done2, pass2, we2;
  logic [3:0] fail2, addr2, wdata2, rdata2;
  logic [4:0] err2;

  logic [7:0] mem  [16];
  logic [3:0] mem2 [16];
  int         fault_mode;
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  ram_bist dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .err_cnt(err_cnt), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  ram_bist #(.ADDR_WIDTH(4), .DATA_WIDTH(4), .SEED(10)) dut_wrap (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .pass(pass2),
    .fail_addr(fail2), .err_cnt(err2), .ram_addr(addr2), .ram_we(we2),
    .ram_wdata(wdata2), .ram_rdata(rdata2)
  );

  function automatic logic [7:0] inject(input logic [7:0] d, input logic [3:0] a, input int mode);
    logic [7:0] r;
    r = d;
    if (mode == 1 && a == 4'd5) r[0] = 1'b0;
    if (mode == 2 && a == 4'd5) r[0] = 1'b1;
    if (mode == 3) r = 8'hFF;
    return r;
  endfunction

  // Registered-read RAM models: data for the address seen at edge k is valid after edge k+1.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= inject(mem[ram_addr], ram_addr, fault_mode);
    if (we2) mem2[addr2] <= wdata2;
    rdata2 <= mem2[addr2];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  // Pulse start (edge 0), then watch up to 200 edges. Optional re-start / reset at given edges.
  task automatic run_test(input int restart_edge, input int rst_edge, output int done_edge,
                          output int we_cycles, output int wd_bad);
    logic [7:0] exp_w;
    done_edge = 0;
    we_cycles = 0;
    wd_bad    = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      if (n == restart_edge) start = 1'b1;
      if (n == rst_edge) rst = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      rst   = 1'b0;
      if (n == rst_edge) begin
        check_eq("rst_busy", busy, 0);
        check_eq("rst_we", ram_we, 0);
        check_eq("rst_err", err_cnt, 0);
        done_edge = -1;
        break;
      end
      if (n == rst_edge - 1) check_eq("busy_mid", busy, 1);
      if (ram_we) begin
        if (ram_addr != 4'(we_cycles % 16)) wd_bad++;
        exp_w = 8'((we_cycles % 16) + 10);
        if (we_cycles >= 16) exp_w = ~exp_w;
        if (ram_wdata != exp_w) wd_bad++;
        we_cycles++;
      end
      if (done) begin
        done_edge = n;
        break;
      end
    end
  endtask

  task automatic check_result(input string tag, input int exp_pass, input int exp_fail,
                              input int exp_err);
    check_eq({tag, "_pass"}, pass, exp_pass);
    check_eq({tag, "_fail_addr"}, fail_addr, exp_fail);
    check_eq({tag, "_err_cnt"}, err_cnt, exp_err);
  endtask

  initial begin
    int de, wc, wb, we_idle;
    logic [3:0] w6, w15;
    logic got6, got15;
    rst = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    fault_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    we_idle = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (ram_we) we_idle++;
    end
    check_eq("idle_we_cycles", we_idle, 0);
    check_eq("rst_busy0", busy, 0);
    check_eq("rst_done0", done, 0);
    check_result("reset", 0, 0, 0);
    check_eq("rst_addr0", ram_addr, 0);
    check_eq("rst_wdata0", ram_wdata, 0);

    // Clean run.
    run_test(0, 0, de, wc, wb);
    check_eq("clean_done_edge", de, ExpDone);
    check_eq("clean_we_cycles", wc, ExpWrites);
    check_eq("clean_wdata_bad", wb, 0);
    check_result("clean", 1, 0, 0);
    @(posedge clk);
    #1;
    check_eq("done_pulse_drop", done, 0);
    check_eq("hold_pass", pass, 1);

    // Bit 0 stuck-at-0 at address 5: pattern 15 reads 14 in the true-polarity pass.
    fault_mode = 1;
    run_test(0, 0, de, wc, wb);
    check_eq("sa0_done_edge", de, ExpDone);
    check_result("sa0", 0, 5, 1);

    // Bit 0 stuck-at-1 at address 5: pattern 15 already has bit 0 set, only ~15 exposes it.
    fault_mode = 2;
    run_test(0, 0, de, wc, wb);
    check_result("sa1", (ExpSa1Err == 0) ? 1 : 0, (ExpSa1Err == 0) ? 0 : 5, ExpSa1Err);

    // Every read returns 0xFF.
    fault_mode = 3;
    run_test(0, 0, de, wc, wb);
    check_eq("ff_done_edge", de, ExpDone);
    check_result("ff", 0, 0, ExpFfErr);
    fault_mode = 0;

    // Second start at edge 8 must be ignored.
    run_test(8, 0, de, wc, wb);
    check_eq("restart_done_edge", de, ExpDone);
    check_eq("restart_we_cycles", wc, ExpWrites);
    check_result("restart", 1, 0, 0);

    // Reset sampled at edge 21 aborts the test.
    fault_mode = 3;
    run_test(0, 21, de, wc, wb);
    check_eq("abort_flag", de, -1);
    check_eq("abort_pass", pass, 0);
    fault_mode = 0;
    run_test(0, 0, de, wc, wb);
    check_eq("after_rst_done_edge", de, ExpDone);
    check_result("after_rst", 1, 0, 0);

    // 4-bit wrap instance: pattern(6) = 0, pattern(15) = 9.
    got6 = 1'b0;
    got15 = 1'b0;
    w6 = '0;
    w15 = '0;
    de = 0;
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (we2 && addr2 == 4'd6 && !got6) begin
        w6 = wdata2;
        got6 = 1'b1;
      end
      if (we2 && addr2 == 4'd15 && !got15) begin
        w15 = wdata2;
        got15 = 1'b1;
      end
      if (done2) begin
        de = n;
        break;
      end
    end
    check_eq("wrap_done_edge", de, ExpDone);
    check_eq("wrap_pat6", w6, 0);
    check_eq("wrap_pat15", w15, 9);
    check_eq("wrap_pass", pass2, 1);
    check_eq("wrap_err", err2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
